// File: rtl/mem_bus_interface_if.sv
// rtl/mem_bus_interface_if.sv - datapath/RAM bus bundle for mem_bus_interface
interface mem_bus_interface_if;
  logic        rd_req;
  logic        wr_req;
  logic [15:0] MAR_in;
  logic [15:0] MDR_in;
  logic [15:0] M_bus_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  // Environment side: issues requests and returns RAM read data
  modport master (
    output rd_req, wr_req, MAR_in, MDR_in, ram_rdata,
    input  M_bus_data, busy, done, err, ram_en, ram_we, ram_addr, ram_wdata
  );

  // Memory stage side
  modport slave (
    input  rd_req, wr_req, MAR_in, MDR_in, ram_rdata,
    output M_bus_data, busy, done, err, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_bus_interface.sv
// rtl/mem_bus_interface.sv - MAR/MDR to synchronous RAM sequencer with done/err reporting
module mem_bus_interface #(
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                CLK,
  input  logic                CLR,
  mem_bus_interface_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  logic [1:0] state;
  logic [2:0] lat_cnt;
  logic       op_wr;
  logic       one_req;
  logic       conflict;
  logic       in_range;

  assign one_req  = bus.rd_req ^ bus.wr_req;
  assign conflict = bus.rd_req & bus.wr_req;
  assign in_range = ({16'd0, bus.MAR_in} < 32'(MEM_DEPTH));

  // FSM and all registered outputs; strobes default low every cycle
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state          <= S_IDLE;
      lat_cnt        <= 3'd0;
      op_wr          <= 1'b0;
      bus.M_bus_data <= 16'd0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.ram_en     <= 1'b0;
      bus.ram_we     <= 1'b0;
      bus.ram_addr   <= 16'd0;
      bus.ram_wdata  <= 16'd0;
    end else begin
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.ram_en <= 1'b0;
      bus.ram_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (conflict) begin
            // A held conflict must not stretch err past one cycle
            bus.err <= ~bus.err;
          end else if (one_req) begin
            if (in_range) begin
              state        <= S_ACCESS;
              op_wr        <= bus.wr_req;
              bus.busy     <= 1'b1;
              bus.ram_en   <= 1'b1;
              bus.ram_we   <= bus.wr_req;
              bus.ram_addr <= bus.MAR_in;
              if (bus.wr_req) begin
                bus.ram_wdata <= bus.MDR_in;
              end
            end else begin
              state    <= S_DONE;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (op_wr) begin
            state    <= S_DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            state   <= S_WAIT;
            lat_cnt <= LAT_M1;
          end
        end
        S_WAIT: begin
          if (lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
          end else begin
            bus.M_bus_data <= bus.ram_rdata;
            state          <= S_DONE;
            bus.done       <= 1'b1;
            bus.busy       <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_interface.sv
// tb/tb_mem_bus_interface.sv - scoreboard bench for mem_bus_interface at RD_LAT 1 and 3
module tb_mem_bus_interface;

  typedef struct {
    logic        d;
    logic        e;
    logic [15:0] data;
    int          cyc;
    int          id;
  } exp_t;

  logic CLK;
  logic CLR;
  int   cyc;
  int   checks;
  int   errors;
  int   busy_cnt1, busy_cnt3, en_cnt1, en_cnt3;
  exp_t q1[$];
  exp_t q3[$];
  exp_t x1, x3;

  logic [15:0] mem1 [0:4095];
  logic [15:0] mem3 [0:4095];
  logic [15:0] pipe1;
  logic [15:0] p3a, p3b, p3c;

  mem_bus_interface_if if1();
  mem_bus_interface_if if3();

  mem_bus_interface #(.MEM_DEPTH(4096), .RD_LAT(1)) u1 (.CLK(CLK), .CLR(CLR), .bus(if1));
  mem_bus_interface #(.MEM_DEPTH(4096), .RD_LAT(3)) u3 (.CLK(CLK), .CLR(CLR), .bus(if3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // RAM models; non-read cycles push garbage so a mistimed capture shows up
  always @(posedge CLK) begin
    if (if1.ram_en && if1.ram_we) mem1[if1.ram_addr[11:0]] <= if1.ram_wdata;
    pipe1 <= (if1.ram_en && !if1.ram_we) ? mem1[if1.ram_addr[11:0]] : 16'hDEAD;
    if (if3.ram_en && if3.ram_we) mem3[if3.ram_addr[11:0]] <= if3.ram_wdata;
    p3a <= (if3.ram_en && !if3.ram_we) ? mem3[if3.ram_addr[11:0]] : 16'hDEAD;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign if1.ram_rdata = pipe1;
  assign if3.ram_rdata = p3c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitors: pop one expectation per done/err pulse
  always @(negedge CLK) begin
    if (if1.done || if1.err) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_resp", {30'd0, if1.done, if1.err}, 32'd0);
      end else begin
        x1 = q1.pop_front();
        chk($sformatf("u1_t%0d_done", x1.id), 32'(if1.done), 32'(x1.d));
        chk($sformatf("u1_t%0d_err", x1.id), 32'(if1.err), 32'(x1.e));
        chk($sformatf("u1_t%0d_data", x1.id), 32'(if1.M_bus_data), 32'(x1.data));
        chk($sformatf("u1_t%0d_cycle", x1.id), 32'(cyc), 32'(x1.cyc));
      end
    end
    if (if3.done || if3.err) begin
      if (q3.size() == 0) begin
        chk("u3_unexpected_resp", {30'd0, if3.done, if3.err}, 32'd0);
      end else begin
        x3 = q3.pop_front();
        chk($sformatf("u3_t%0d_done", x3.id), 32'(if3.done), 32'(x3.d));
        chk($sformatf("u3_t%0d_err", x3.id), 32'(if3.err), 32'(x3.e));
        chk($sformatf("u3_t%0d_data", x3.id), 32'(if3.M_bus_data), 32'(x3.data));
        chk($sformatf("u3_t%0d_cycle", x3.id), 32'(cyc), 32'(x3.cyc));
      end
    end
  end

  // Activity counters for busy length and RAM strobe count
  always @(negedge CLK) begin
    if (if1.busy) busy_cnt1++;
    if (if3.busy) busy_cnt3++;
    if (if1.ram_en) en_cnt1++;
    if (if3.ram_en) en_cnt3++;
  end

  task automatic drive(input int inst, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] dat);
    if (inst == 1) begin
      if1.rd_req = rd; if1.wr_req = wr; if1.MAR_in = addr; if1.MDR_in = dat;
    end else begin
      if3.rd_req = rd; if3.wr_req = wr; if3.MAR_in = addr; if3.MDR_in = dat;
    end
  endtask

  task automatic check_zero(input int inst, input string tag);
    logic [15:0] mb, ra, rw;
    logic [4:0]  fl;
    if (inst == 1) begin
      mb = if1.M_bus_data; ra = if1.ram_addr; rw = if1.ram_wdata;
      fl = {if1.busy, if1.done, if1.err, if1.ram_en, if1.ram_we};
    end else begin
      mb = if3.M_bus_data; ra = if3.ram_addr; rw = if3.ram_wdata;
      fl = {if3.busy, if3.done, if3.err, if3.ram_en, if3.ram_we};
    end
    chk({tag, "_M_bus_data"}, 32'(mb), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ra), 32'd0);
    chk({tag, "_ram_wdata"}, 32'(rw), 32'd0);
    chk({tag, "_flags"}, 32'(fl), 32'd0);
  endtask

  // One request sampled at a single edge; expectation derived from op and address
  task automatic issue(input int inst, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wdat,
                       input logic [15:0] exp_data, input int id);
    exp_t x;
    int   lat, b0, e0, b1, e1, exp_busy;
    logic valid, en_v, we_v;
    logic [15:0] ad_v, wd_v;
    lat   = (inst == 1) ? 1 : 3;
    valid = (rd ^ wr) && (addr < 16'h1000);
    @(negedge CLK);
    drive(inst, rd, wr, addr, wdat);
    x.id = id;
    x.data = exp_data;
    if (rd && wr)   begin x.d = 1'b0; x.e = 1'b1; x.cyc = cyc + 1; end
    else if (!valid) begin x.d = 1'b1; x.e = 1'b1; x.cyc = cyc + 1; end
    else if (wr)     begin x.d = 1'b1; x.e = 1'b0; x.cyc = cyc + 2; end
    else             begin x.d = 1'b1; x.e = 1'b0; x.cyc = cyc + 2 + lat; end
    if (inst == 1) begin q1.push_back(x); b0 = busy_cnt1; e0 = en_cnt1; end
    else           begin q3.push_back(x); b0 = busy_cnt3; e0 = en_cnt3; end
    @(negedge CLK);
    drive(inst, 1'b0, 1'b0, addr, wdat);
    if (inst == 1) begin en_v = if1.ram_en; we_v = if1.ram_we; ad_v = if1.ram_addr; wd_v = if1.ram_wdata; end
    else           begin en_v = if3.ram_en; we_v = if3.ram_we; ad_v = if3.ram_addr; wd_v = if3.ram_wdata; end
    chk($sformatf("t%0d_c1_ram_en", id), 32'(en_v), 32'(valid));
    if (valid) begin
      chk($sformatf("t%0d_c1_ram_we", id), 32'(we_v), 32'(wr));
      chk($sformatf("t%0d_c1_ram_addr", id), 32'(ad_v), 32'(addr));
      if (wr) chk($sformatf("t%0d_c1_ram_wdata", id), 32'(wd_v), 32'(wdat));
    end
    repeat (10) @(negedge CLK);
    if (inst == 1) begin b1 = busy_cnt1; e1 = en_cnt1; end
    else           begin b1 = busy_cnt3; e1 = en_cnt3; end
    exp_busy = !valid ? 0 : (wr ? 1 : 1 + lat);
    chk($sformatf("t%0d_busy_cycles", id), 32'(b1 - b0), 32'(exp_busy));
    chk($sformatf("t%0d_ram_en_cycles", id), 32'(e1 - e0), 32'(valid ? 1 : 0));
  endtask

  initial begin
    int   k, e0;
    exp_t x;
    cyc = 0; checks = 0; errors = 0;
    busy_cnt1 = 0; busy_cnt3 = 0; en_cnt1 = 0; en_cnt3 = 0;
    CLR = 1'b1;
    drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(3, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge CLK);
    CLR = 1'b0;
    check_zero(1, "rst_u1");
    check_zero(3, "rst_u3");

    issue(1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1);
    issue(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 2);
    issue(1, 1'b1, 1'b1, 16'h0020, 16'h7777, 16'hBEEF, 3);
    issue(1, 1'b1, 1'b0, 16'h1000, 16'h0000, 16'hBEEF, 4);

    // Requests toggled while busy are dropped; rd_req held over DONE restarts once
    @(negedge CLK);
    drive(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    k = cyc;
    e0 = en_cnt1;
    x.d = 1'b1; x.e = 1'b0; x.data = 16'hBEEF;
    x.cyc = k + 3; x.id = 5; q1.push_back(x);
    x.cyc = k + 7; x.id = 6; q1.push_back(x);
    @(negedge CLK); drive(1, 1'b1, 1'b1, 16'h0030, 16'h5555);
    @(negedge CLK); drive(1, 1'b1, 1'b0, 16'h0030, 16'h5555);
    @(negedge CLK); drive(1, 1'b1, 1'b1, 16'h0030, 16'h5555);
    @(negedge CLK); drive(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("t6_idle_gap_ram_en", 32'(if1.ram_en), 32'd0);
    @(negedge CLK); drive(1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    chk("t6_restart_ram_en", 32'(if1.ram_en), 32'd1);
    chk("t6_restart_ram_we", 32'(if1.ram_we), 32'd0);
    chk("t6_restart_ram_addr", 32'(if1.ram_addr), 32'h0010);
    repeat (8) @(negedge CLK);
    chk("t6_ram_en_total", 32'(en_cnt1 - e0), 32'd2);

    issue(3, 1'b0, 1'b1, 16'h0FFF, 16'h1234, 16'h0000, 7);
    issue(3, 1'b1, 1'b0, 16'h0FFF, 16'h0000, 16'h1234, 8);
    issue(3, 1'b0, 1'b1, 16'hFFFF, 16'hAAAA, 16'h1234, 9);

    // Reset during WAIT of an RD_LAT=3 read: no response, everything cleared
    @(negedge CLK); drive(3, 1'b1, 1'b0, 16'h0FFF, 16'h0000);
    @(negedge CLK); drive(3, 1'b0, 1'b0, 16'h0FFF, 16'h0000);
    @(negedge CLK); CLR = 1'b1;
    @(negedge CLK); CLR = 1'b0;
    check_zero(3, "midrst_u3");
    repeat (8) @(negedge CLK);
    issue(3, 1'b1, 1'b0, 16'h0FFF, 16'h0000, 16'h1234, 10);

    chk("u1_pending_resp", 32'(q1.size()), 32'd0);
    chk("u3_pending_resp", 32'(q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
